// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the shift normalizer.
package shift_normalizer_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    typedef enum logic [1:0] {
        NORM_LEFT   = 2'd0,
        NORM_RIGHT  = 2'd1,
        NORM_SIGNED = 2'd2,
        NORM_PASS   = 2'd3
    } norm_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/shift_normalizer_if.sv
// Request/result handshake bundle between a requester and the shift normalizer.
interface shift_normalizer_if;
    import shift_normalizer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] B;
    logic [1:0]        CTRL;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Y;
    logic [AMT_W-1:0]  A;
    logic              ZERO;

    modport master (
        output in_valid, B, CTRL, out_ready,
        input  in_ready, out_valid, Y, A, ZERO
    );

    modport slave (
        input  in_valid, B, CTRL, out_ready,
        output in_ready, out_valid, Y, A, ZERO
    );
endinterface

// File: rtl/shift_normalizer_norm_step.sv
// One conditional normalization step of size i_size on the working value.
module norm_step
    import shift_normalizer_pkg::*;
(
    input  logic [DATA_W-1:0] i_value,
    input  norm_mode_e        i_mode,
    input  logic [AMT_W-1:0]  i_size,
    output logic [DATA_W-1:0] o_value,
    output logic              o_taken
);
    localparam logic [DATA_W-1:0] ONES = '1;

    logic [DATA_W-1:0] w_top_k;
    logic [DATA_W-1:0] w_top_k1;
    logic [DATA_W-1:0] w_bot_k;

    always_comb begin
        w_top_k  = ~(ONES >> i_size);
        // signed mode tests one extra bit so the sign bit survives the shift
        w_top_k1 = ~(ONES >> ({1'b0, i_size} + 6'd1));
        w_bot_k  = ~(ONES << i_size);
        o_value  = i_value;
        o_taken  = 1'b0;
        case (i_mode)
            NORM_LEFT: begin
                o_taken = ((i_value & w_top_k) == '0);
                if (o_taken) o_value = i_value << i_size;
            end
            NORM_RIGHT: begin
                o_taken = ((i_value & w_bot_k) == '0);
                if (o_taken) o_value = i_value >> i_size;
            end
            NORM_SIGNED: begin
                o_taken = ((i_value & w_top_k1) == '0) || ((i_value & w_top_k1) == w_top_k1);
                if (o_taken) o_value = i_value << i_size;
            end
            default: begin
                o_taken = 1'b0;
                o_value = i_value;
            end
        endcase
    end
endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: five binary-search steps (16,8,4,2,1) with valid/ready handshake.
module shift_normalizer
    import shift_normalizer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    shift_normalizer_if.slave bus
);
    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_step;
    logic [DATA_W-1:0] r_val;
    norm_mode_e        r_mode;
    logic [AMT_W-1:0]  r_amt;
    logic              r_zero;

    logic [DATA_W-1:0] w_step_val;
    logic              w_taken;
    logic [AMT_W-1:0]  w_size;
    logic              w_accept;
    logic              w_last;

    assign w_size = 5'd16 >> r_step;
    assign w_last = (r_step == 3'd4);

    norm_step u_step (
        .i_value (r_val),
        .i_mode  (r_mode),
        .i_size  (w_size),
        .o_value (w_step_val),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                w_accept     = bus.in_valid;
                if (bus.in_valid) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ZERO is registered so it reads 0 during reset while Y also reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val  <= '0;
            r_mode <= NORM_LEFT;
            r_amt  <= '0;
            r_step <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_val  <= bus.B;
            r_mode <= norm_mode_e'(bus.CTRL);
            r_amt  <= '0;
            r_step <= '0;
            r_zero <= 1'b0;
        end else if (r_state == RUN) begin
            r_val  <= w_step_val;
            r_step <= r_step + 3'd1;
            if (w_taken) r_amt <= r_amt + w_size;
            if (w_last)  r_zero <= (w_step_val == '0);
        end
    end

    assign bus.Y    = r_val;
    assign bus.A    = r_amt;
    assign bus.ZERO = r_zero;
endmodule

// File: tb/tb_shift_normalizer.sv
// Directed-vector and model-based bench for shift_normalizer.
module tb_shift_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    shift_normalizer_if bus();

    shift_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] b;
        logic [31:0] y;
        logic [4:0]  a;
        logic        z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] m, input logic [31:0] b,
                                  output logic [31:0] y, output logic [4:0] a);
        int n = 0;
        case (m)
            2'd0: begin while (n < 31 && b[31-n] == 1'b0) n++; y = b << n; end
            2'd1: begin while (n < 31 && b[n] == 1'b0) n++; y = b >> n; end
            2'd2: begin while (n < 31 && b[30-n] == b[31]) n++; y = b << n; end
            default: begin n = 0; y = b; end
        endcase
        a = 5'(n);
    endfunction

    task automatic run_req(input logic [1:0] m, input logic [31:0] b, input int unsigned stall,
                           output logic [31:0] y, output logic [4:0] a, output logic z);
        int unsigned guard = 0;
        int lat;
        logic ok;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.B = b;
        bus.CTRL = m;
        bus.out_ready = 1'b0;
        while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
        check("in_ready_wait", 32'(guard < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        bus.in_valid = 1'b0;
        bus.B = ~b;
        bus.CTRL = ~m;
        while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("latency", lat, 6);
        y = bus.Y;
        a = bus.A;
        z = bus.ZERO;
        ok = 1'b1;
        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bus.Y !== y || bus.A !== a || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) ok = 1'b0;
        end
        if (stall > 0) check("stall_hold", ok, 1'b1);
        bus.in_valid = 1'b1;
        check("done_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("back_to_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] y, ey;
        logic [4:0]  a, ea;
        logic        z;
        logic [1:0]  m;
        logic [31:0] b;

        bus.in_valid = 1'b0;
        bus.B = '0;
        bus.CTRL = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{2'd0, 32'h00001234, 32'h91A00000, 5'd19, 1'b0});
        vecs.push_back('{2'd1, 32'h00050000, 32'h00000005, 5'd16, 1'b0});
        vecs.push_back('{2'd2, 32'hFFFFF000, 32'h80000000, 5'd19, 1'b0});
        vecs.push_back('{2'd0, 32'h00000000, 32'h00000000, 5'd31, 1'b1});
        vecs.push_back('{2'd1, 32'h00000000, 32'h00000000, 5'd31, 1'b1});
        vecs.push_back('{2'd2, 32'h00000000, 32'h00000000, 5'd31, 1'b1});
        vecs.push_back('{2'd3, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  1'b0});
        vecs.push_back('{2'd3, 32'h00000000, 32'h00000000, 5'd0,  1'b1});
        vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'h80000000, 5'd31, 1'b0});
        vecs.push_back('{2'd0, 32'h00000001, 32'h80000000, 5'd31, 1'b0});
        vecs.push_back('{2'd1, 32'h80000000, 32'h00000001, 5'd31, 1'b0});
        vecs.push_back('{2'd2, 32'h00000001, 32'h40000000, 5'd30, 1'b0});
        vecs.push_back('{2'd2, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0,  1'b0});
        vecs.push_back('{2'd1, 32'h00001234, 32'h0000048D, 5'd2,  1'b0});
        vecs.push_back('{2'd0, 32'h80000000, 32'h80000000, 5'd0,  1'b0});

        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_Y", bus.Y, 32'h0);
        check("rst_A", bus.A, 5'd0);
        check("rst_ZERO", bus.ZERO, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_req(vecs[i].m, vecs[i].b, (i == 0) ? 10 : 0, y, a, z);
            check($sformatf("vec%0d_Y", i), y, vecs[i].y);
            check($sformatf("vec%0d_A", i), a, vecs[i].a);
            check($sformatf("vec%0d_ZERO", i), z, vecs[i].z);
        end

        // reset in the middle of RUN aborts the operation
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.B = 32'h00001234;
        bus.CTRL = 2'd0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", bus.out_valid, 1'b0);
        check("midrun_rst_in_ready", bus.in_ready, 1'b1);
        check("midrun_rst_Y", bus.Y, 32'h0);
        check("midrun_rst_A", bus.A, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        run_req(2'd0, 32'h00001234, 0, y, a, z);
        check("post_rst_Y", y, 32'h91A00000);
        check("post_rst_A", a, 5'd19);
        check("post_rst_ZERO", z, 1'b0);

        for (int k = 0; k < 150; k++) begin
            m = 2'($urandom_range(0, 3));
            b = $urandom() >> $urandom_range(0, 31);
            if (m == 2'd2 && $urandom_range(0, 1) == 1) b = ~b;
            model(m, b, ey, ea);
            run_req(m, b, $urandom_range(0, 2), y, a, z);
            check($sformatf("rnd%0d_Y", k), y, ey);
            check($sformatf("rnd%0d_A", k), a, ea);
            check($sformatf("rnd%0d_ZERO", k), z, 32'(ey == 32'h0));
            if (b != 32'h0) begin
                case (m)
                    2'd0: check($sformatf("rnd%0d_inv", k), 32'(((y >> a) == b)), 32'd1);
                    2'd1: check($sformatf("rnd%0d_inv", k), 32'(((y << a) == b)), 32'd1);
                    2'd2: check($sformatf("rnd%0d_inv", k), 32'(($signed(y) >>> a) == $signed(b)), 32'd1);
                    default: check($sformatf("rnd%0d_pass", k), y, b);
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: in_valid  input  1  request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: B  input  32  operand to normalize.
REQ-007 Port: CTRL  input  2  mode: 0 left-normalize (leading zeros), 1 right-normalize (trailing zeros), 2 signed-normalize (redundant sign bits), 3 pass-through.
REQ-008 Port: out_valid  output  1  result valid.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: Y  output  32  normalized value.
REQ-011 Port: A  output  5  shift amount applied; same encoding as the ALU shifter amount.
REQ-012 Port: ZERO  output  1  normalized result is all-zero.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 Accept occurs on a clock edge with in_valid=1 and in_ready=1; B and CTRL are captured there, later input changes are ignored; the FSM moves IDLE->RUN and A clears to 0.
REQ-015 RUN SHALL last exactly 5 cycles, applying step sizes 16,8,4,2,1 in order, one step per cycle; after the step-1 cycle, RUN->DONE.
REQ-016 Mode 0 step k: if the top k bits of the working value are 0, shift it logically left by k and add k to A.
REQ-017 Mode 1 step k: if the bottom k bits are 0, shift it logically right by k and add k to A.
REQ-018 Mode 2 step k: if the top k+1 bits are all equal, shift it left by k and add k to A.
REQ-019 Mode 3: the working value and A are unchanged through all 5 RUN cycles; latency equals the other modes.
REQ-020 Accept-to-out_valid latency SHALL be 6 cycles; out_valid rises in the cycle after the 5th RUN cycle.
REQ-021 In DONE, Y, A and ZERO are held stable until an edge with out_ready=1; then DONE->IDLE.
REQ-022 A new accept SHALL NOT occur in the same cycle as the DONE->IDLE transition (in_ready is still 0 then); peak throughput is one result per 7 cycles.
REQ-023 A zero operand in modes 0, 1 or 2 SHALL give Y=0, A=31, ZERO=1.
REQ-024 In mode 2 an all-ones operand SHALL give Y=0x80000000, A=31, ZERO=0.
REQ-025 ZERO SHALL equal (Y==0) in every mode, including mode 3.
REQ-026 A never exceeds 31; the adder is 5 bits wide and cannot overflow, since the steps sum to 31.
REQ-027 Inverse property for nonzero B: mode 0 gives Y>>A == B; mode 1 gives Y<<A == B; mode 2 gives $signed(Y)>>>A == B.

Reset
REQ-028 rst SHALL force IDLE, in_ready=1, out_valid=0, Y=0, A=0 and ZERO=0 immediately, independent of clk.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation with no result emitted; the first accept after reset release proceeds normally.

Structure
REQ-030 A shared package SHALL hold the CTRL mode enum (NORM_LEFT, NORM_RIGHT, NORM_SIGNED, NORM_PASS), the FSM state typedef, and constants DATA_W=32 and AMT_W=5.
REQ-031 One combinational sub-module, norm_step, SHALL implement a single conditional step (inputs: value, mode, step size; outputs: next value, taken flag); the top level owns the FSM, the step counter, the A accumulator and the handshake.

Verification
REQ-032 Mode 0, B=0x00001234, out_ready=1 -> out_valid 6 cycles after accept; Y=0x91A00000, A=19, ZERO=0.
REQ-033 Mode 1, B=0x00050000 -> Y=0x00000005, A=16; mode 2, B=0xFFFFF000 -> Y=0x80000000, A=19.
REQ-034 Modes 0, 1 and 2 with B=0 -> Y=0, A=31, ZERO=1; mode 3 with B=0xDEADBEEF -> Y=0xDEADBEEF, A=0, ZERO=0.
REQ-035 out_ready held 0 for 10 cycles in DONE -> Y and A stable and in_ready=0 throughout; a B change during RUN does not alter the result.
REQ-036 rst pulsed mid-RUN -> out_valid=0 and in_ready=1 immediately; the next request gives the correct result.
REQ-037 Random B and CTRL, 10k requests -> Y and A match a reference model and the REQ-027 inverse property holds.
